// File: rtl/lsu_byte_seq_pkg.sv
// Shared funct3 codes, FSM encoding and request decode helpers
// for the byte-serial load/store sequencer.
package lsu_byte_seq_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_RESP
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return (f3 == F3_SB) || (f3 == F3_SH) ||
             (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) ||
           (f3 == F3_LW) || (f3 == F3_LBU) ||
           (f3 == F3_LHU);
  endfunction

  // Index of the final byte lane: 0 for B, 1 for H, 3 for W
  function automatic logic [1:0] f3_last(
    input logic [2:0] f3
  );
    if (f3[1])
      return 2'd3;
    if (f3[0])
      return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/lsu_byte_seq_extend.sv
// Load result extension: funct3 plus assembled little-endian
// bytes in, sign/zero extended 32-bit value out.
module lsu_extend
  import lsu_byte_seq_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (func3_i)
      F3_LB:   data_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_LH:   data_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_LW:   data_o = data_i;
      F3_LBU:  data_o = {24'd0, data_i[7:0]};
      F3_LHU:  data_o = {16'd0, data_i[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store initiator: splits each core request
// into little-endian single-byte memory accesses.
module lsu_byte_seq
  import lsu_byte_seq_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              err_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [31:0]       ext;
  logic              acc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE:
        if (req_valid)
          state_d = f3_legal(req_we, req_func3) ?
                    LSU_ACCESS : LSU_RESP;
      LSU_ACCESS:
        if (idx_q == last_q)
          state_d = LSU_RESP;
      LSU_RESP:
        state_d = LSU_IDLE;
      default:
        state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LSU_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_func3;
        we_q    <= req_we;
        err_q   <= !f3_legal(req_we, req_func3);
        idx_q   <= '0;
        last_q  <= f3_last(req_func3);
        rbuf_q  <= '0;
      end else if (state_q == LSU_ACCESS) begin
        idx_q <= idx_q + 2'd1;
        if (!we_q)
          rbuf_q[{idx_q, 3'b000} +: 8] <= mem_rdata;
      end
    end
  end

  lsu_extend u_ext (
    .func3_i (f3_q),
    .data_i  (rbuf_q),
    .data_o  (ext)
  );

  // Memory strobes and address are forced to 0 outside ACCESS
  assign acc        = (state_q == LSU_ACCESS);
  assign mem_addr   = acc ? addr_q + ADDR_W'(idx_q) : '0;
  assign mem_we     = acc && we_q;
  assign mem_re     = acc && !we_q;
  assign mem_wdata  = mem_we ?
                      wdata_q[{idx_q, 3'b000} +: 8] : '0;
  assign req_ready  = (state_q == LSU_IDLE);
  assign resp_valid = (state_q == LSU_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !we_q && !err_q) ?
                      ext : '0;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Directed bench for lsu_byte_seq with a 256-byte memory
// model aliased on the low address byte.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [256];
  logic        clr;

  int cmps = 0;
  int errs = 0;

  logic [31:0] t_addr [8];
  logic [7:0]  t_wd   [8];
  int          r_cyc;
  logic [31:0] r_data;
  logic        r_err;
  int          n_we;
  int          n_re;
  int          n_both;

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[7:0]];

  task automatic run_req(input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_cyc = 0; r_data = 'x; r_err = 1'bx;
    n_we = 0; n_re = 0; n_both = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      t_addr[c-1] = mem_addr;
      t_wd[c-1]   = mem_wdata;
      n_we += int'(mem_we);
      n_re += int'(mem_re);
      n_both += int'(mem_we && mem_re);
      if (resp_valid) begin
        r_cyc  = c;
        r_data = resp_rdata;
        r_err  = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b1; req_valid = 1'b0;
    req_we = 1'b0; req_func3 = 3'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    rst = 1'b0;
    #1;
    cmps++;
    if ({req_ready, resp_valid, resp_err, mem_we, mem_re}
        !== 5'b10000) begin
      errs++;
      $display("FAIL rst_ctl got %b want 10000",
        {req_ready, resp_valid, resp_err, mem_we, mem_re});
    end
    cmps++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 72'd0) begin
      errs++;
      $display("FAIL rst_data got %h %h %h want 0",
        resp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_sw;
    logic [7:0] exp_b [4];
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    cmps++;
    if (r_cyc !== 5 || n_we !== 4 || n_re !== 0) begin
      errs++;
      $display("FAIL sw_seq got cyc=%0d we=%0d re=%0d want 5 4 0",
        r_cyc, n_we, n_re);
    end
    for (int i = 0; i < 4; i++) begin
      cmps++;
      if (t_addr[i] !== 32'h10 + i || t_wd[i] !== exp_b[i]) begin
        errs++;
        $display("FAIL sw_byte%0d got %h:%h want %h:%h", i,
          t_addr[i], t_wd[i], 32'h10 + i, exp_b[i]);
      end
    end
    cmps++;
    if (r_data !== 32'h0 || r_err !== 1'b0) begin
      errs++;
      $display("FAIL sw_resp got %h err=%b want 0 0",
        r_data, r_err);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [5];
    logic [31:0] ad [5];
    logic [31:0] ex [5];
    int          lt [5];
    f3 = '{3'b010, 3'b001, 3'b101, 3'b000, 3'b100};
    ad = '{32'h10, 32'h12, 32'h12, 32'h11, 32'h11};
    ex = '{32'hDEADBEEF, 32'hFFFFDEAD, 32'h0000DEAD,
           32'hFFFFFFBE, 32'h000000BE};
    lt = '{5, 3, 3, 2, 2};
    for (int k = 0; k < 5; k++) begin
      run_req(1'b0, f3[k], ad[k], 32'hFFFFFFFF);
      cmps++;
      if (r_cyc !== lt[k] || n_re !== lt[k] - 1 ||
          n_we !== 0 || r_data !== ex[k] || r_err !== 1'b0) begin
        errs++;
        $display("FAIL load%0d got cyc=%0d re=%0d we=%0d d=%h e=%b want %0d %0d 0 %h 0",
          k, r_cyc, n_re, n_we, r_data, r_err,
          lt[k], lt[k] - 1, ex[k]);
      end
    end
  endtask

  task automatic test_sb;
    run_req(1'b1, 3'b000, 32'h11, 32'h12345600);
    cmps++;
    if (r_cyc !== 2 || n_we !== 1 || t_addr[0] !== 32'h11 ||
        t_wd[0] !== 8'h00) begin
      errs++;
      $display("FAIL sb_seq got cyc=%0d we=%0d %h:%h want 2 1 11:00",
        r_cyc, n_we, t_addr[0], t_wd[0]);
    end
    cmps++;
    if (mem[8'h10] !== 8'hEF || mem[8'h11] !== 8'h00 ||
        mem[8'h12] !== 8'hAD) begin
      errs++;
      $display("FAIL sb_mem got %h %h %h want ef 00 ad",
        mem[8'h10], mem[8'h11], mem[8'h12]);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0);
    cmps++;
    if (r_data !== 32'hDEAD00EF) begin
      errs++;
      $display("FAIL sb_lw got %h want dead00ef", r_data);
    end
  endtask

  task automatic test_unaligned;
    run_req(1'b0, 3'b010, 32'h13, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cmps++;
      if (t_addr[i] !== 32'h13 + i) begin
        errs++;
        $display("FAIL ua_addr%0d got %h want %h", i,
          t_addr[i], 32'h13 + i);
      end
    end
    cmps++;
    if (r_data !== 32'h000000DE || r_cyc !== 5) begin
      errs++;
      $display("FAIL ua_data got %h cyc=%0d want 000000de 5",
        r_data, r_cyc);
    end
  endtask

  task automatic test_wrap;
    run_req(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000034);
    run_req(1'b1, 3'b000, 32'h00000000, 32'h00000092);
    run_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    cmps++;
    if (t_addr[0] !== 32'hFFFFFFFF || t_addr[1] !== 32'h0) begin
      errs++;
      $display("FAIL wrap_addr got %h %h want ffffffff 0",
        t_addr[0], t_addr[1]);
    end
    cmps++;
    if (r_data !== 32'hFFFF9234) begin
      errs++;
      $display("FAIL wrap_data got %h want ffff9234", r_data);
    end
  endtask

  task automatic test_illegal;
    run_req(1'b0, 3'b011, 32'h10, 32'h0);
    cmps++;
    if (r_cyc !== 1 || r_err !== 1'b1 || r_data !== 32'h0 ||
        n_we !== 0 || n_re !== 0) begin
      errs++;
      $display("FAIL ill_ld got cyc=%0d e=%b d=%h we=%0d re=%0d want 1 1 0 0 0",
        r_cyc, r_err, r_data, n_we, n_re);
    end
    run_req(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    cmps++;
    if (r_cyc !== 1 || r_err !== 1'b1 || n_we !== 0) begin
      errs++;
      $display("FAIL ill_st got cyc=%0d e=%b we=%0d want 1 1 0",
        r_cyc, r_err, n_we);
    end
    cmps++;
    if (mem[8'h10] !== 8'hEF) begin
      errs++;
      $display("FAIL ill_mem got %h want ef", mem[8'h10]);
    end
  endtask

  task automatic test_busy;
    logic [11:0] rv_m;
    logic [11:0] rdy_m;
    logic [31:0] d2;
    rv_m = '0; rdy_m = '0; d2 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0;
    req_func3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      rv_m[c]  = resp_valid;
      rdy_m[c] = req_ready;
      if (c == 11) d2 = resp_rdata;
    end
    req_valid = 1'b0;
    cmps++;
    if (rv_m !== 12'b1000_0010_0000) begin
      errs++;
      $display("FAIL busy_resp got %b want 100000100000", rv_m);
    end
    cmps++;
    if (rdy_m !== 12'b0000_0100_0000) begin
      errs++;
      $display("FAIL busy_rdy got %b want 000001000000", rdy_m);
    end
    cmps++;
    if (d2 !== 32'hDEAD00EF) begin
      errs++;
      $display("FAIL busy_data got %h want dead00ef", d2);
    end
  endtask

  task automatic test_mid_reset;
    int seen;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    cmps++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h20 ||
        mem_wdata !== 8'h44) begin
      errs++;
      $display("FAIL mr_c1 got %b %h %h want 1 20 44",
        mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmps++;
    if ({req_ready, resp_valid, mem_we, mem_re} !== 4'b1000 ||
        mem_addr !== 32'h0 || mem_wdata !== 8'h0 ||
        resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errs++;
      $display("FAIL mr_async got rdy=%b rv=%b we=%b re=%b a=%h wd=%h",
        req_ready, resp_valid, mem_we, mem_re, mem_addr, mem_wdata);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen += int'(resp_valid) + int'(mem_we);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen += int'(resp_valid) + int'(mem_we);
    end
    cmps++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL mr_quiet got %0d want 0", seen);
    end
    cmps++;
    if (mem[8'h20] !== 8'h44 || mem[8'h21] !== 8'h00) begin
      errs++;
      $display("FAIL mr_mem got %h %h want 44 00",
        mem[8'h20], mem[8'h21]);
    end
    run_req(1'b0, 3'b010, 32'h20, 32'h0);
    cmps++;
    if (r_cyc !== 5 || r_data !== 32'h00000044) begin
      errs++;
      $display("FAIL mr_after got cyc=%0d d=%h want 5 00000044",
        r_cyc, r_data);
    end
  endtask

  task automatic test_exclusive;
    cmps++;
    if (n_both !== 0) begin
      errs++;
      $display("FAIL we_re_both got %0d want 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_exclusive();
    test_loads();
    test_exclusive();
    test_sb();
    test_unaligned();
    test_wrap();
    test_illegal();
    test_busy();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      cmps, errs);
    $finish;
  end

endmodule
